sec_countdown_timer: RTL and testbench

Seconds-resolution countdown timer for the fitness-tracker datapath, the down-counting counterpart of the up-counting elapsed-seconds counter. It loads a seconds value, decrements it once per second of the system clock while enabled, and signals expiry. It drives interval and workout timers and the display's "time remaining" field.

---
 rtl/sec_countdown_timer.sv | 105 ++++++++++
 tb/tb_sec_countdown_timer.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/sec_countdown_timer.sv
// Seconds-resolution countdown timer with a free prescaler, pause and expiry pulse.
// Optional feature: define COUNTDOWN_AUTORELOAD_EN to reload from the last loaded value on expiry.
module sec_countdown_timer #(
  parameter int unsigned TICKS_PER_SEC = 100000000,
  parameter int unsigned WIDTH         = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  input  logic             RUN,
  output logic [WIDTH-1:0] SecLeft,
  output logic             RUNNING,
  output logic             TICK,
  output logic             EXPIRED
);

  localparam int unsigned PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {IDLE, COUNT, PAUSED, DONE} state_t;

  state_t           state, state_nx;
  logic [PW-1:0]    pre, pre_nx;
  logic [WIDTH-1:0] sec_nx;
  logic             tick_nx, exp_nx;
`ifdef COUNTDOWN_AUTORELOAD_EN
  logic [WIDTH-1:0] reload, reload_nx;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      pre     <= '0;
      SecLeft <= '0;
      TICK    <= 1'b0;
      EXPIRED <= 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
      reload  <= '0;
`endif
    end else begin
      state   <= state_nx;
      pre     <= pre_nx;
      SecLeft <= sec_nx;
      TICK    <= tick_nx;
      EXPIRED <= exp_nx;
`ifdef COUNTDOWN_AUTORELOAD_EN
      reload  <= reload_nx;
`endif
    end
  end

  always_comb begin
    state_nx = state;
    pre_nx   = pre;
    sec_nx   = SecLeft;
    tick_nx  = 1'b0;
    exp_nx   = 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
    reload_nx = reload;
`endif
    if (LOAD) begin
`ifdef COUNTDOWN_AUTORELOAD_EN
      reload_nx = LOAD_VAL;
`endif
      pre_nx = '0;
      if (LOAD_VAL == '0) begin
        sec_nx   = '0;
        state_nx = DONE;
      end else begin
        sec_nx   = LOAD_VAL;
        state_nx = RUN ? COUNT : PAUSED;
      end
    end else begin
      unique case (state)
        // The edge that sees RUN low still advances the prescaler, so a pause
        // of P cycles delays later ticks by exactly P cycles.
        COUNT: begin
          state_nx = RUN ? COUNT : PAUSED;
          if (pre == PRE_MAX) begin
            pre_nx  = '0;
            tick_nx = 1'b1;
            sec_nx  = (SecLeft == '0) ? '0 : SecLeft - WIDTH'(1);
            if (SecLeft == WIDTH'(1)) begin
              exp_nx = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
              if (reload != '0) sec_nx = reload;
              else              state_nx = DONE;
`else
              state_nx = DONE;
`endif
            end
          end else begin
            pre_nx = pre + PW'(1);
          end
        end
        PAUSED:  if (RUN) state_nx = COUNT;
        default: ;
      endcase
    end
  end

  assign RUNNING = (state == COUNT);

endmodule

// File: tb/tb_sec_countdown_timer.sv
// Self-checking bench: directed test-plan scenarios plus random stimulus against
// an arithmetic model (seconds left = loaded - counting_cycles / TICKS_PER_SEC).
module tb_sec_countdown_timer;
  localparam int T = 10;
  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RESET = 1'b0, LOAD = 1'b0, RUN = 1'b0;
  logic [W-1:0] LOAD_VAL = '0;
  logic [W-1:0] SecLeft;
  logic         RUNNING, TICK, EXPIRED;

  sec_countdown_timer #(.TICKS_PER_SEC(T), .WIDTH(W)) dut (
    .CLK(CLK), .RESET(RESET), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL), .RUN(RUN),
    .SecLeft(SecLeft), .RUNNING(RUNNING), .TICK(TICK), .EXPIRED(EXPIRED)
  );

  always #5 CLK = ~CLK;

  int errors = 0, checks = 0;
  int m_sec = 0, m_run = 0, m_tick = 0, m_exp = 0, m_active = 0, m_loaded = 0, m_cycles = 0;
  int cyc = 0, load_cyc = 0;
  int tick_q[$], exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic chk_q(input string tag, input int got[$], input int want[$]);
    chk({tag, "_count"}, got.size(), want.size());
    for (int i = 0; i < want.size(); i++)
      chk($sformatf("%s_%0d", tag, i), (i < got.size()) ? got[i] : -1, want[i]);
  endtask

  // One clock: drive inputs, advance the model, sample 1 time unit after the edge.
  task automatic step(input logic r, input logic l, input int lv, input logic run_i);
    RESET = r; LOAD = l; LOAD_VAL = W'(lv); RUN = run_i;
    @(posedge CLK);
    cyc++;
    m_tick = 0; m_exp = 0;
    if (r) begin
      m_sec = 0; m_run = 0; m_active = 0; m_loaded = 0; m_cycles = 0;
    end else if (l) begin
      m_loaded = lv; m_cycles = 0; load_cyc = cyc;
      tick_q.delete(); exp_q.delete();
      if (lv == 0) begin m_sec = 0; m_active = 0; m_run = 0; end
      else begin m_sec = lv; m_active = 1; m_run = run_i; end
    end else if (m_active != 0) begin
      if (m_run != 0) begin
        m_cycles++;
        if (m_cycles % T == 0) begin
          m_tick = 1;
          m_sec = m_loaded - m_cycles / T;
          if (m_sec == 0) begin
            m_exp = 1;
`ifdef COUNTDOWN_AUTORELOAD_EN
            m_sec = m_loaded; m_cycles = 0; m_run = run_i;
`else
            m_active = 0; m_run = 0;
`endif
          end else m_run = run_i;
        end else m_run = run_i;
      end else m_run = run_i;
    end
    #1;
    if (TICK === 1'b1) tick_q.push_back(cyc - load_cyc);
    if (EXPIRED === 1'b1) exp_q.push_back(cyc - load_cyc);
    chk("sec_left", 32'(SecLeft), m_sec);
    chk("running", 32'(RUNNING), m_run);
    chk("tick", 32'(TICK), m_tick);
    chk("expired", 32'(EXPIRED), m_exp);
  endtask

  initial begin
    logic rr, ll, run_r;
    int lv;
    #2;
    // Reset held three cycles
    repeat (3) step(1, 0, 0, 0);
    chk("reset_sec", 32'(SecLeft), 0);
    chk("reset_running", 32'(RUNNING), 0);

`ifdef COUNTDOWN_AUTORELOAD_EN
    // Auto-reload: expiry every 20 cycles, counting never stops
    step(0, 1, 2, 1);
    repeat (60) step(0, 0, 0, 1);
    chk_q("ar_exp", exp_q, '{20, 40, 60});
    chk_q("ar_tick", tick_q, '{10, 20, 30, 40, 50, 60});
    chk("ar_running", 32'(RUNNING), 1);
    chk("ar_sec", 32'(SecLeft), 2);
`else
    // Three-second countdown
    step(0, 1, 3, 1);
    chk("load_sec", 32'(SecLeft), 3);
    repeat (32) step(0, 0, 0, 1);
    chk_q("t3_tick", tick_q, '{10, 20, 30});
    chk_q("t3_exp", exp_q, '{30});
    chk("t3_running_after", 32'(RUNNING), 0);
    chk("t3_sec_after", 32'(SecLeft), 0);
`endif

    // Pause of seven cycles starting at cycle 14
    step(0, 1, 5, 1);
    for (int i = 1; i <= 57; i++) step(0, 0, 0, (i >= 14 && i <= 20) ? 1'b0 : 1'b1);
    chk_q("pause_tick", tick_q, '{10, 27, 37, 47, 57});
    chk_q("pause_exp", exp_q, '{57});

    // Load coinciding with a second tick
    step(0, 1, 7, 1);
    repeat (9) step(0, 0, 0, 1);
    step(0, 1, 2, 1);
    chk("lot_tick", 32'(TICK), 0);
    chk("lot_sec", 32'(SecLeft), 2);
    repeat (10) step(0, 0, 0, 1);
    chk_q("lot_next_tick", tick_q, '{10});

    // Load of zero goes straight to done without an expiry pulse
    step(0, 1, 0, 1);
    repeat (25) step(0, 0, 0, 1);
    chk("zero_sec", 32'(SecLeft), 0);
    chk("zero_running", 32'(RUNNING), 0);
    chk("zero_exp_count", exp_q.size(), 0);

    // Reset in the middle of a long count
    step(0, 1, 200, 1);
    repeat (35) step(0, 0, 0, 1);
    step(1, 1, 9, 1);
    chk("midreset_sec", 32'(SecLeft), 0);
    chk("midreset_running", 32'(RUNNING), 0);
    chk("midreset_tick", 32'(TICK), 0);

    // Random stimulus against the model
    run_r = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      rr = ($urandom_range(0, 299) == 0);
      ll = ($urandom_range(0, 29) == 0);
      lv = $urandom_range(0, 4);
      if ($urandom_range(0, 11) == 0) run_r = ~run_r;
      step(rr, ll, lv, run_r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
